// File: rtl/imm_gen_stage_if.sv
// Handshake bus for imm_gen_stage.
//   in_*  : upstream entry (valid/ready, raw instruction, pc)
//   out_* : decoded entry to downstream (valid/ready, instr, pc, imm, type,
//           illegal flag, precomputed target)
// master: the side driving in_* and out_ready; slave: the stage itself.
interface imm_gen_stage_if #(
  parameter int unsigned XLEN = 32
) ();
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;

  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_instr;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_type;
  logic            out_illegal;
  logic [XLEN-1:0] out_target;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, out_imm, out_type,
           out_illegal, out_target
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_imm, out_type,
           out_illegal, out_target
  );
endinterface

// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage between fetch and decode.
// Decodes instruction format from the opcode, extracts the extended
// immediate, flags illegal opcodes and precomputes pc+imm / pc+4.
// A main register plus one skid register keep full throughput under
// backpressure.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset (drops entries, zeroes data)
//   flush  : synchronous kill of all buffered entries
//   bus    : imm_gen_stage_if slave (in_* upstream, out_* downstream)
module imm_gen_stage #(
  parameter int unsigned XLEN     = 32,
  parameter bit          RV64_OPS = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  imm_gen_stage_if.slave    bus
);

  localparam bit RV64_EN = RV64_OPS && (XLEN == 64);

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  localparam logic [2:0] TYPE_NONE = 3'd0;
  localparam logic [2:0] TYPE_I    = 3'd1;
  localparam logic [2:0] TYPE_S    = 3'd2;
  localparam logic [2:0] TYPE_B    = 3'd3;
  localparam logic [2:0] TYPE_U    = 3'd4;
  localparam logic [2:0] TYPE_J    = 3'd5;
  localparam logic [2:0] TYPE_Z    = 3'd6;

  // Bit 0 = main valid, bit 1 = skid valid, so handshake outputs are flop bits.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_e;

  state_e state, state_nxt;
  logic   load_main, load_skid, move_skid;
  logic   accept, consume;

  // ---------------------------------------------------------------
  // Combinational decode of the incoming entry
  // ---------------------------------------------------------------
  logic [31:0]     instr;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_z;
  logic [XLEN-1:0] shamt_full, shamt_w;
  logic [XLEN-1:0] d_imm, d_target;
  logic [2:0]      d_type;
  logic            d_illegal, use_target;

  assign instr  = bus.in_instr;
  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];

  assign imm_i = XLEN'($signed(instr[31:20]));
  assign imm_s = XLEN'($signed({instr[31:25], instr[11:7]}));
  assign imm_b = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({instr[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
  assign imm_z = XLEN'(instr[19:15]);

  // Shift amounts exclude instr[30] (the arithmetic-shift selector).
  assign shamt_full = (XLEN == 64) ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);
  assign shamt_w    = XLEN'(instr[24:20]);

  always_comb begin
    d_type     = TYPE_NONE;
    d_imm      = '0;
    d_illegal  = 1'b0;
    use_target = 1'b0;
    case (opcode)
      OPC_OP_IMM: begin
        d_type = TYPE_I;
        d_imm  = (funct3[1:0] == 2'b01) ? shamt_full : imm_i;
      end
      OPC_OP_IMM_32: begin
        if (RV64_EN) begin
          d_type = TYPE_I;
          d_imm  = (funct3[1:0] == 2'b01) ? shamt_w : imm_i;
        end else begin
          d_illegal = 1'b1;
        end
      end
      OPC_LOAD, OPC_JALR, OPC_MISC_MEM: begin
        d_type = TYPE_I;
        d_imm  = imm_i;
      end
      OPC_STORE: begin
        d_type = TYPE_S;
        d_imm  = imm_s;
      end
      OPC_BRANCH: begin
        d_type     = TYPE_B;
        d_imm      = imm_b;
        use_target = 1'b1;
      end
      OPC_LUI: begin
        d_type = TYPE_U;
        d_imm  = imm_u;
      end
      OPC_AUIPC: begin
        d_type     = TYPE_U;
        d_imm      = imm_u;
        use_target = 1'b1;
      end
      OPC_JAL: begin
        d_type     = TYPE_J;
        d_imm      = imm_j;
        use_target = 1'b1;
      end
      OPC_OP: begin
        d_type = TYPE_NONE;
      end
      OPC_OP_32: begin
        d_illegal = !RV64_EN;
      end
      OPC_SYSTEM: begin
        if (funct3[2]) begin
          d_type = TYPE_Z;
          d_imm  = imm_z;
        end else begin
          d_type = TYPE_I;
          d_imm  = imm_i;
        end
      end
      // Unknown opcodes, including any encoding with instr[1:0] != 2'b11.
      default: d_illegal = 1'b1;
    endcase
  end

  assign d_target = bus.in_pc + (use_target ? d_imm : XLEN'(4));

  // ---------------------------------------------------------------
  // Handshake FSM
  // ---------------------------------------------------------------
  assign bus.out_valid = state[0];
  assign bus.in_ready  = ~state[1];

  assign accept  = bus.in_valid  & ~state[1];
  assign consume = bus.out_ready & state[0];

  // Next state and register-load strobes; flush overrides any transfer.
  always_comb begin
    state_nxt = state;
    load_main = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state_nxt = ONE;
            load_main = 1'b1;
          end
        end
        ONE: begin
          if (consume && accept) begin
            load_main = 1'b1;
          end else if (consume) begin
            state_nxt = EMPTY;
          end else if (accept) begin
            state_nxt = FULL;
            load_skid = 1'b1;
          end
        end
        FULL: begin
          if (consume) begin
            state_nxt = ONE;
            move_skid = 1'b1;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // ---------------------------------------------------------------
  // State, main and skid registers (data loads only on capture)
  // ---------------------------------------------------------------
  logic [31:0]     main_instr,   skid_instr;
  logic [XLEN-1:0] main_pc,      skid_pc;
  logic [XLEN-1:0] main_imm,     skid_imm;
  logic [2:0]      main_type,    skid_type;
  logic            main_illegal, skid_illegal;
  logic [XLEN-1:0] main_target,  skid_target;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= EMPTY;
      main_instr   <= '0;
      main_pc      <= '0;
      main_imm     <= '0;
      main_type    <= TYPE_NONE;
      main_illegal <= 1'b0;
      main_target  <= '0;
      skid_instr   <= '0;
      skid_pc      <= '0;
      skid_imm     <= '0;
      skid_type    <= TYPE_NONE;
      skid_illegal <= 1'b0;
      skid_target  <= '0;
    end else begin
      state <= state_nxt;
      if (load_main) begin
        main_instr   <= bus.in_instr;
        main_pc      <= bus.in_pc;
        main_imm     <= d_imm;
        main_type    <= d_type;
        main_illegal <= d_illegal;
        main_target  <= d_target;
      end else if (move_skid) begin
        main_instr   <= skid_instr;
        main_pc      <= skid_pc;
        main_imm     <= skid_imm;
        main_type    <= skid_type;
        main_illegal <= skid_illegal;
        main_target  <= skid_target;
      end
      if (load_skid) begin
        skid_instr   <= bus.in_instr;
        skid_pc      <= bus.in_pc;
        skid_imm     <= d_imm;
        skid_type    <= d_type;
        skid_illegal <= d_illegal;
        skid_target  <= d_target;
      end
    end
  end

  assign bus.out_instr   = main_instr;
  assign bus.out_pc      = main_pc;
  assign bus.out_imm     = main_imm;
  assign bus.out_type    = main_type;
  assign bus.out_illegal = main_illegal;
  assign bus.out_target  = main_target;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed bench for imm_gen_stage: an RV32 instance and an RV64 instance
// (RV64_OPS=1) driven through their interfaces, checked against
// hand-computed expected values.
module tb_imm_gen_stage;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;

  always #5 clk = ~clk;

  imm_gen_stage_if #(.XLEN(32)) bus32 ();
  imm_gen_stage_if #(.XLEN(64)) bus64 ();

  imm_gen_stage #(.XLEN(32), .RV64_OPS(1'b0)) u_dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus32)
  );

  imm_gen_stage #(.XLEN(64), .RV64_OPS(1'b1)) u_dut64 (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus64)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive32(input logic [31:0] instr, input logic [31:0] pc);
    bus32.in_valid = 1'b1;
    bus32.in_instr = instr;
    bus32.in_pc    = pc;
  endtask

  task automatic drive64(input logic [31:0] instr, input logic [63:0] pc);
    bus64.in_valid = 1'b1;
    bus64.in_instr = instr;
    bus64.in_pc    = pc;
  endtask

  task automatic expect32(input string tag, input logic [2:0] typ, input logic [31:0] imm,
                          input logic [31:0] tgt, input logic ill);
    check_val({tag, ".valid"},   64'(bus32.out_valid),   64'd1);
    check_val({tag, ".type"},    64'(bus32.out_type),    64'(typ));
    check_val({tag, ".imm"},     64'(bus32.out_imm),     64'(imm));
    check_val({tag, ".target"},  64'(bus32.out_target),  64'(tgt));
    check_val({tag, ".illegal"}, 64'(bus32.out_illegal), 64'(ill));
  endtask

  task automatic expect64(input string tag, input logic [2:0] typ, input logic [63:0] imm,
                          input logic [63:0] tgt, input logic ill);
    check_val({tag, ".valid"},   64'(bus64.out_valid),   64'd1);
    check_val({tag, ".type"},    64'(bus64.out_type),    64'(typ));
    check_val({tag, ".imm"},     bus64.out_imm,          imm);
    check_val({tag, ".target"},  bus64.out_target,       tgt);
    check_val({tag, ".illegal"}, 64'(bus64.out_illegal), 64'(ill));
  endtask

  localparam logic [31:0] I_ADDI  = 32'hFFF0_0093;
  localparam logic [31:0] I_BEQ   = 32'hFE00_0EE3;
  localparam logic [31:0] I_SRAI  = 32'h4030_D093;
  localparam logic [31:0] I_CSRWI = 32'h3002_D073;
  localparam logic [31:0] I_BAD   = 32'h0000_007F;

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    bus32.in_valid = 1'b0; bus32.in_instr = '0; bus32.in_pc = '0; bus32.out_ready = 1'b1;
    bus64.in_valid = 1'b0; bus64.in_instr = '0; bus64.in_pc = '0; bus64.out_ready = 1'b1;
    step();
    step();

    // Reset state
    check_val("rst.valid",   64'(bus32.out_valid),   64'd0);
    check_val("rst.ready",   64'(bus32.in_ready),    64'd1);
    check_val("rst.imm",     64'(bus32.out_imm),     64'd0);
    check_val("rst.illegal", 64'(bus32.out_illegal), 64'd0);
    check_val("rst.target",  64'(bus32.out_target),  64'd0);
    check_val("rst64.valid", 64'(bus64.out_valid),   64'd0);
    rst_n = 1'b1;

    // RV32 decode, one entry per cycle at full throughput
    drive32(I_ADDI, 32'h100); step();
    expect32("addi", 3'd1, 32'hFFFF_FFFF, 32'h104, 1'b0);
    check_val("addi.pc",    64'(bus32.out_pc),    64'h100);
    check_val("addi.instr", 64'(bus32.out_instr), 64'(I_ADDI));

    drive32(I_BEQ, 32'h100); step();
    expect32("beq", 3'd3, 32'hFFFF_FFFC, 32'h0000_00FC, 1'b0);

    drive32(I_SRAI, 32'h200); step();
    expect32("srai", 3'd1, 32'h3, 32'h204, 1'b0);

    drive32(I_CSRWI, 32'h300); step();
    expect32("csrrwi", 3'd6, 32'h5, 32'h304, 1'b0);

    drive32(I_BAD, 32'h400); step();
    expect32("bad_opc", 3'd0, 32'h0, 32'h404, 1'b1);

    drive32(32'hFE20_AC23, 32'h500); step();
    expect32("sw", 3'd2, 32'hFFFF_FFF8, 32'h504, 1'b0);

    drive32(32'h0080_006F, 32'hFFFF_FFFC); step();
    expect32("jal_wrap", 3'd5, 32'h8, 32'h0000_0004, 1'b0);

    drive32(32'h0010_809B, 32'h600); step();
    expect32("addiw_rv32", 3'd0, 32'h0, 32'h604, 1'b1);

    drive32(32'h0000_0010, 32'h700); step();
    expect32("quadrant", 3'd0, 32'h0, 32'h704, 1'b1);

    drive32(32'h0020_80B3, 32'h800); step();
    expect32("add", 3'd0, 32'h0, 32'h804, 1'b0);

    bus32.in_valid = 1'b0; step();
    check_val("drain.valid", 64'(bus32.out_valid), 64'd0);

    // Backpressure: A in main, B in skid, C stalls, then all drain in order
    bus32.out_ready = 1'b0;
    drive32(I_ADDI, 32'h1000); step();
    check_val("bp.a.instr", 64'(bus32.out_instr), 64'(I_ADDI));
    check_val("bp.a.ready", 64'(bus32.in_ready),  64'd1);
    drive32(I_BEQ, 32'h1004); step();
    check_val("bp.hold1.instr", 64'(bus32.out_instr), 64'(I_ADDI));
    check_val("bp.hold1.imm",   64'(bus32.out_imm),   64'hFFFF_FFFF);
    check_val("bp.full.ready",  64'(bus32.in_ready),  64'd0);
    drive32(I_SRAI, 32'h1008); step();
    check_val("bp.hold2.pc",    64'(bus32.out_pc),    64'h1000);
    check_val("bp.hold2.ready", 64'(bus32.in_ready),  64'd0);
    bus32.out_ready = 1'b1; step();
    check_val("bp.b.instr",  64'(bus32.out_instr),  64'(I_BEQ));
    check_val("bp.b.target", 64'(bus32.out_target), 64'h1000);
    check_val("bp.b.ready",  64'(bus32.in_ready),   64'd1);
    step();
    check_val("bp.c.instr", 64'(bus32.out_instr), 64'(I_SRAI));
    check_val("bp.c.imm",   64'(bus32.out_imm),   64'h3);
    bus32.in_valid = 1'b0; step();
    check_val("bp.end.valid", 64'(bus32.out_valid), 64'd0);

    // Flush from ONE with a concurrent input: that input is dropped
    drive32(I_ADDI, 32'h1800); step();
    drive32(I_CSRWI, 32'h1804); flush = 1'b1; step();
    flush = 1'b0; bus32.in_valid = 1'b0;
    check_val("flush1.valid", 64'(bus32.out_valid), 64'd0);
    step();
    check_val("flush1.after", 64'(bus32.out_valid), 64'd0);

    // Flush from FULL with in_valid high
    bus32.out_ready = 1'b0;
    drive32(I_ADDI, 32'h2000); step();
    drive32(I_BEQ,  32'h2004); step();
    check_val("flush2.full", 64'(bus32.in_ready), 64'd0);
    drive32(I_CSRWI, 32'h2008); flush = 1'b1; step();
    flush = 1'b0; bus32.in_valid = 1'b0;
    check_val("flush2.valid", 64'(bus32.out_valid), 64'd0);
    check_val("flush2.ready", 64'(bus32.in_ready),  64'd1);
    bus32.out_ready = 1'b1; step(); step();
    check_val("flush2.after", 64'(bus32.out_valid), 64'd0);

    // Reset from FULL with in_valid high: entries dropped, data zeroed
    bus32.out_ready = 1'b0;
    drive32(I_BAD, 32'h3000); step();
    drive32(I_BEQ, 32'h3004); step();
    check_val("rst2.pre_illegal", 64'(bus32.out_illegal), 64'd1);
    check_val("rst2.pre_ready",   64'(bus32.in_ready),    64'd0);
    drive32(I_ADDI, 32'h3008); rst_n = 1'b0; step();
    rst_n = 1'b1; bus32.in_valid = 1'b0;
    check_val("rst2.valid",   64'(bus32.out_valid),   64'd0);
    check_val("rst2.ready",   64'(bus32.in_ready),    64'd1);
    check_val("rst2.instr",   64'(bus32.out_instr),   64'd0);
    check_val("rst2.pc",      64'(bus32.out_pc),      64'd0);
    check_val("rst2.imm",     64'(bus32.out_imm),     64'd0);
    check_val("rst2.type",    64'(bus32.out_type),    64'd0);
    check_val("rst2.illegal", 64'(bus32.out_illegal), 64'd0);
    check_val("rst2.target",  64'(bus32.out_target),  64'd0);
    bus32.out_ready = 1'b1; step();
    check_val("rst2.after", 64'(bus32.out_valid), 64'd0);

    // RV64 instance with RV64_OPS enabled
    drive64(32'h8000_00B7, 64'h0000_0001_0000_0000); step();
    expect64("lui64", 3'd4, 64'hFFFF_FFFF_8000_0000, 64'h0000_0001_0000_0004, 1'b0);
    drive64(32'h03F0_9093, 64'h100); step();
    expect64("slli63", 3'd1, 64'd63, 64'h104, 1'b0);
    drive64(32'h0010_809B, 64'h200); step();
    expect64("addiw", 3'd1, 64'd1, 64'h204, 1'b0);
    drive64(32'h03F0_909B, 64'h300); step();
    expect64("slliw_b25", 3'd1, 64'd31, 64'h304, 1'b0);
    drive64(32'hFFFF_F097, 64'h1000); step();
    expect64("auipc_neg", 3'd4, 64'hFFFF_FFFF_FFFF_F000, 64'h0, 1'b0);
    drive64(32'h0000_003B, 64'h400); step();
    expect64("op32", 3'd0, 64'h0, 64'h404, 1'b0);
    drive64(I_BEQ, 64'h0); step();
    expect64("beq_wrap64", 3'd3, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    bus64.in_valid = 1'b0; step();
    check_val("rv64.drain", 64'(bus64.out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
